// File: rtl/combat_resolver_pkg.sv
// Shared definitions for the fighter datapath: widths, player state codes,
// combat tuning defaults and the resolver FSM encoding.
package combat_resolver_pkg;

  localparam int STATE_DEPTH        = 3;
  localparam int SPRITE_INDEX_DEPTH = 4;
  localparam int POSITION_DEPTH     = 10;
  localparam int PLAYER_WIDTH       = 32;

  localparam logic [STATE_DEPTH-1:0] NOTHING    = 3'd0;
  localparam logic [STATE_DEPTH-1:0] WALK_LEFT  = 3'd1;
  localparam logic [STATE_DEPTH-1:0] WALK_RIGHT = 3'd2;
  localparam logic [STATE_DEPTH-1:0] BLOCK      = 3'd3;
  localparam logic [STATE_DEPTH-1:0] KICK       = 3'd4;
  localparam logic [STATE_DEPTH-1:0] GRAB       = 3'd5;
  localparam logic [STATE_DEPTH-1:0] WIN        = 3'd6;
  localparam logic [STATE_DEPTH-1:0] LOSE       = 3'd7;

  localparam int unsigned DEF_KICK_ACTIVE_START = 2;
  localparam int unsigned DEF_KICK_ACTIVE_END   = 3;
  localparam int unsigned DEF_KICK_RANGE        = 20;
  localparam int unsigned DEF_GRAB_ACTIVE_FRAME = 1;
  localparam int unsigned DEF_GRAB_RANGE        = 8;
  localparam int unsigned DEF_TIMEOUT_CYCLES    = 16;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_DONE = 3'd1,
    S_COMPUTE   = 3'd2,
    S_RESOLVE   = 3'd3,
    S_LOCKED    = 3'd4
  } resolver_state_e;

endpackage

// File: rtl/combat_resolver_frame_edge_sync.sv
// Two-flop synchroniser for the asynchronous frame clock followed by a
// rising-edge detector; frame_edge_o is one sys_clk cycle wide.
module frame_edge_sync (
  input  logic sys_clk,
  input  logic reset,
  input  logic frame_clk_i,
  output logic frame_edge_o
);

  logic sync1_q, sync2_q, prev_q;

  // synchronise frame_clk and keep the previous synchronised level
  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= frame_clk_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign frame_edge_o = sync2_q & ~prev_q;

endmodule

// File: rtl/combat_resolver.sv
// Per-frame hit resolver between the two player next-state calculators.
// State | meaning
//   IDLE      | waiting for a frame edge
//   WAIT_DONE | waiting for both done flags (or the timeout)
//   COMPUTE   | capture range/active-frame checks from the inputs
//   RESOLVE   | decide who landed using only captured values
//   LOCKED    | a hit landed; round over until reset
module combat_resolver
  import combat_resolver_pkg::*;
#(
  parameter int unsigned KICK_ACTIVE_START = DEF_KICK_ACTIVE_START,
  parameter int unsigned KICK_ACTIVE_END   = DEF_KICK_ACTIVE_END,
  parameter int unsigned KICK_RANGE        = DEF_KICK_RANGE,
  parameter int unsigned GRAB_ACTIVE_FRAME = DEF_GRAB_ACTIVE_FRAME,
  parameter int unsigned GRAB_RANGE        = DEF_GRAB_RANGE,
  parameter int unsigned TIMEOUT_CYCLES    = DEF_TIMEOUT_CYCLES
) (
  input  logic                          sys_clk,
  input  logic                          reset,
  input  logic                          frame_clk,
  input  logic [STATE_DEPTH-1:0]        p1_state,
  input  logic [SPRITE_INDEX_DEPTH-1:0] p1_index,
  input  logic [POSITION_DEPTH-1:0]     p1_position,
  input  logic                          p1_done,
  input  logic [STATE_DEPTH-1:0]        p2_state,
  input  logic [SPRITE_INDEX_DEPTH-1:0] p2_index,
  input  logic [POSITION_DEPTH-1:0]     p2_position,
  input  logic                          p2_done,
  output logic                          p1_attack_connected,
  output logic                          p2_attack_connected,
  output logic                          round_over,
  output logic                          resolve_valid,
  output logic                          clash,
  output logic                          frame_overrun
);

  localparam int GAP_W = POSITION_DEPTH + 1;
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [SPRITE_INDEX_DEPTH-1:0] KICK_START_IDX = SPRITE_INDEX_DEPTH'(KICK_ACTIVE_START);
  localparam logic [SPRITE_INDEX_DEPTH-1:0] KICK_END_IDX   = SPRITE_INDEX_DEPTH'(KICK_ACTIVE_END);
  localparam logic [SPRITE_INDEX_DEPTH-1:0] GRAB_IDX       = SPRITE_INDEX_DEPTH'(GRAB_ACTIVE_FRAME);
  localparam logic [GAP_W-1:0]              KICK_REACH     = GAP_W'(KICK_RANGE);
  localparam logic [GAP_W-1:0]              GRAB_REACH     = GAP_W'(GRAB_RANGE);
  localparam logic [CNT_W-1:0]              CNT_LAST       = CNT_W'(TIMEOUT_CYCLES - 1);

  resolver_state_e  state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             frame_edge;
  logic [GAP_W-1:0] p1_front, gap;
  logic             kick_p1_c, kick_p2_c, grab_p1_c, grab_p2_c, ended_c;
  logic             kick_p1_q, kick_p2_q, grab_p1_q, grab_p2_q, ended_q;
  logic [STATE_DEPTH-1:0] p1_state_q, p2_state_q;
  logic             lands_p1, lands_p2, capture;
  logic             p1_hit_q, p1_hit_d, p2_hit_q, p2_hit_d, overrun_q, overrun_d;

  frame_edge_sync u_frame_edge_sync (
    .sys_clk      (sys_clk),
    .reset        (reset),
    .frame_clk_i  (frame_clk),
    .frame_edge_o (frame_edge)
  );

  // gap between the players (saturating at 0 on overlap) and attack reach checks
  always_comb begin
    p1_front  = {1'b0, p1_position} + GAP_W'(PLAYER_WIDTH);
    gap       = ({1'b0, p2_position} < p1_front) ? '0 : ({1'b0, p2_position} - p1_front);
    kick_p1_c = (p1_state == KICK) && (p1_index >= KICK_START_IDX) &&
                (p1_index <= KICK_END_IDX) && (gap <= KICK_REACH);
    kick_p2_c = (p2_state == KICK) && (p2_index >= KICK_START_IDX) &&
                (p2_index <= KICK_END_IDX) && (gap <= KICK_REACH);
    grab_p1_c = (p1_state == GRAB) && (p1_index == GRAB_IDX) && (gap <= GRAB_REACH);
    grab_p2_c = (p2_state == GRAB) && (p2_index == GRAB_IDX) && (gap <= GRAB_REACH);
    ended_c   = (p1_state == WIN) || (p1_state == LOSE) ||
                (p2_state == WIN) || (p2_state == LOSE);
  end

  // a finished round (WIN/LOSE) suppresses both hits so it cannot re-trigger
  assign lands_p1 = ~ended_q & ((kick_p1_q & (p2_state_q != BLOCK)) |
                                (grab_p1_q & (p2_state_q != KICK)));
  assign lands_p2 = ~ended_q & ((kick_p2_q & (p1_state_q != BLOCK)) |
                                (grab_p2_q & (p1_state_q != KICK)));

  // next-state, counter and result decisions
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    capture       = 1'b0;
    p1_hit_d      = p1_hit_q;
    p2_hit_d      = p2_hit_q;
    overrun_d     = overrun_q;
    resolve_valid = 1'b0;
    clash         = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (frame_edge) begin
          state_d = S_WAIT_DONE;
          cnt_d   = '0;
        end
      end
      S_WAIT_DONE: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (frame_edge) begin
          overrun_d = 1'b1;
          cnt_d     = '0;
        end else if ((p1_done && p2_done) || (cnt_q == CNT_LAST)) begin
          state_d = S_COMPUTE;
        end
      end
      S_COMPUTE: begin
        capture = 1'b1;
        if (frame_edge) begin
          overrun_d = 1'b1;
          state_d   = S_WAIT_DONE;
          cnt_d     = '0;
        end else begin
          state_d = S_RESOLVE;
        end
      end
      S_RESOLVE: begin
        resolve_valid = 1'b1;
        if (frame_edge) overrun_d = 1'b1;
        if (lands_p1 && lands_p2) begin
          clash = 1'b1;
        end else if (lands_p1) begin
          p1_hit_d = 1'b1;
        end else if (lands_p2) begin
          p2_hit_d = 1'b1;
        end
        if (lands_p1 != lands_p2) begin
          state_d = S_LOCKED;
        end else begin
          state_d = frame_edge ? S_WAIT_DONE : S_IDLE;
          cnt_d   = '0;
        end
      end
      S_LOCKED: begin
        state_d = S_LOCKED;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // FSM, counter and sticky result registers
  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      p1_hit_q  <= 1'b0;
      p2_hit_q  <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      p1_hit_q  <= p1_hit_d;
      p2_hit_q  <= p2_hit_d;
      overrun_q <= overrun_d;
    end
  end

  // snapshot of the frame's attack checks taken in COMPUTE
  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      kick_p1_q  <= 1'b0;
      kick_p2_q  <= 1'b0;
      grab_p1_q  <= 1'b0;
      grab_p2_q  <= 1'b0;
      ended_q    <= 1'b0;
      p1_state_q <= NOTHING;
      p2_state_q <= NOTHING;
    end else if (capture) begin
      kick_p1_q  <= kick_p1_c;
      kick_p2_q  <= kick_p2_c;
      grab_p1_q  <= grab_p1_c;
      grab_p2_q  <= grab_p2_c;
      ended_q    <= ended_c;
      p1_state_q <= p1_state;
      p2_state_q <= p2_state;
    end
  end

  assign p1_attack_connected = p1_hit_q;
  assign p2_attack_connected = p2_hit_q;
  assign round_over          = p1_hit_q | p2_hit_q;
  assign frame_overrun       = overrun_q;

endmodule

// File: tb/tb_combat_resolver.sv
// Directed bench for combat_resolver: hit rules, range boundaries, timeout,
// overrun, lock-out and asynchronous reset.
module tb_combat_resolver;
  import combat_resolver_pkg::*;

  logic                          sys_clk, reset, frame_clk;
  logic [STATE_DEPTH-1:0]        p1_state, p2_state;
  logic [SPRITE_INDEX_DEPTH-1:0] p1_index, p2_index;
  logic [POSITION_DEPTH-1:0]     p1_position, p2_position;
  logic                          p1_done, p2_done;
  logic p1_attack_connected, p2_attack_connected, round_over;
  logic resolve_valid, clash, frame_overrun;

  int n_vec  = 0;
  int n_miss = 0;

  combat_resolver dut (
    .sys_clk             (sys_clk),
    .reset               (reset),
    .frame_clk           (frame_clk),
    .p1_state            (p1_state),
    .p1_index            (p1_index),
    .p1_position         (p1_position),
    .p1_done             (p1_done),
    .p2_state            (p2_state),
    .p2_index            (p2_index),
    .p2_position         (p2_position),
    .p2_done             (p2_done),
    .p1_attack_connected (p1_attack_connected),
    .p2_attack_connected (p2_attack_connected),
    .round_over          (round_over),
    .resolve_valid       (resolve_valid),
    .clash               (clash),
    .frame_overrun       (frame_overrun)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_players(input logic [2:0] s1, input int i1, input int x1,
                             input logic [2:0] s2, input int i2, input int x2);
    p1_state    = s1;
    p1_index    = SPRITE_INDEX_DEPTH'(i1);
    p1_position = POSITION_DEPTH'(x1);
    p2_state    = s2;
    p2_index    = SPRITE_INDEX_DEPTH'(i2);
    p2_position = POSITION_DEPTH'(x2);
  endtask

  task automatic do_reset();
    frame_clk = 1'b0;
    reset     = 1'b0;
    repeat (2) @(posedge sys_clk);
    #1 reset = 1'b1;
  endtask

  // Raise frame_clk; count sys_clk edges until resolve_valid (-1 if none in 40).
  // The edge detector fires 2 edges after the rise, so a normal frame resolves at 5
  // and a timed-out frame at 2 + TIMEOUT_CYCLES + 2 = 20.
  task automatic run_frame(input string tag, input int exp_lat, input int exp_clash,
                           input int exp_p1, input int exp_p2);
    int lat;
    bit seen;
    int clash_s;
    lat = 0; seen = 0; clash_s = 0;
    frame_clk = 1'b1;
    while (!seen && lat < 40) begin
      @(posedge sys_clk); #1;
      lat++;
      if (resolve_valid) begin
        seen    = 1;
        clash_s = int'(clash);
      end
    end
    chk({tag, "_lat"}, seen ? lat : -1, exp_lat);
    chk({tag, "_clash"}, clash_s, exp_clash);
    @(posedge sys_clk); #1;
    chk({tag, "_p1"}, int'(p1_attack_connected), exp_p1);
    chk({tag, "_p2"}, int'(p2_attack_connected), exp_p2);
    chk({tag, "_rnd"}, int'(round_over), exp_p1 | exp_p2);
    chk({tag, "_pulse"}, int'(resolve_valid | clash), 0);
    frame_clk = 1'b0;
    repeat (3) @(posedge sys_clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; frame_clk = 1'b0;
    p1_done = 1'b1; p2_done = 1'b1;
    set_players(NOTHING, 0, 100, NOTHING, 0, 200);
    #2;
    chk("rst_p1",  int'(p1_attack_connected), 0);
    chk("rst_p2",  int'(p2_attack_connected), 0);
    chk("rst_rnd", int'(round_over), 0);
    chk("rst_rv",  int'(resolve_valid), 0);
    chk("rst_cl",  int'(clash), 0);
    chk("rst_ovr", int'(frame_overrun), 0);
    do_reset();

    // block stops kick, then grab beats block-free opponent and locks the round
    set_players(KICK, 2, 100, BLOCK, 0, 100 + PLAYER_WIDTH + 10);
    run_frame("blk", 5, 0, 0, 0);
    set_players(NOTHING, 0, 100, GRAB, 1, 100 + PLAYER_WIDTH + 5);
    run_frame("grab", 5, 0, 0, 1);
    set_players(KICK, 2, 100, NOTHING, 0, 100 + PLAYER_WIDTH + 10);
    run_frame("lock", -1, 0, 0, 1);
    chk("lock_ovr", int'(frame_overrun), 0);
    do_reset();

    // plain kick in range
    set_players(KICK, 2, 100, NOTHING, 0, 100 + PLAYER_WIDTH + 10);
    run_frame("kick", 5, 0, 1, 0);
    do_reset();

    // clash, then grab into an inactive kick
    set_players(KICK, 3, 100, KICK, 3, 100 + PLAYER_WIDTH + 15);
    run_frame("clash", 5, 1, 0, 0);
    set_players(GRAB, 1, 100, KICK, 0, 100 + PLAYER_WIDTH + 5);
    run_frame("gvk", 5, 0, 0, 0);

    // kick range boundary and overlap saturation
    set_players(KICK, 2, 100, NOTHING, 0, 100 + PLAYER_WIDTH + 21);
    run_frame("gap21", 5, 0, 0, 0);
    set_players(KICK, 2, 100, NOTHING, 0, 100 + PLAYER_WIDTH + 20);
    run_frame("gap20", 5, 0, 1, 0);
    do_reset();
    set_players(KICK, 3, 100, NOTHING, 0, 102);
    run_frame("ovl", 5, 0, 1, 0);
    do_reset();

    // timeout: p2 never done, kick out of range
    p2_done = 1'b0;
    set_players(KICK, 2, 100, NOTHING, 0, 100 + PLAYER_WIDTH + 30);
    run_frame("tmo", 20, 0, 0, 0);
    chk("tmo_ovr", int'(frame_overrun), 0);

    // overrun: second frame rise during WAIT_DONE restarts the wait
    set_players(KICK, 2, 100, NOTHING, 0, 100 + PLAYER_WIDTH + 10);
    frame_clk = 1'b1;
    repeat (3) @(posedge sys_clk);
    #1 frame_clk = 1'b0;
    repeat (3) @(posedge sys_clk);
    #1;
    chk("ovr_pre", int'(frame_overrun), 0);
    run_frame("ovr", 20, 0, 1, 0);
    chk("ovr_flag", int'(frame_overrun), 1);
    p2_done = 1'b1;
    do_reset();
    chk("rst2_ovr", int'(frame_overrun), 0);

    // reset asserted while in COMPUTE
    set_players(KICK, 2, 100, NOTHING, 0, 100 + PLAYER_WIDTH + 10);
    frame_clk = 1'b1;
    repeat (4) @(posedge sys_clk);
    #1;
    chk("mid_state", int'(dut.state_q), int'(S_COMPUTE));
    reset = 1'b0;
    frame_clk = 1'b0;
    #1;
    chk("mid_fsm", int'(dut.state_q), int'(S_IDLE));
    chk("mid_rv",  int'(resolve_valid), 0);
    chk("mid_rnd", int'(round_over), 0);
    repeat (3) @(posedge sys_clk);
    #1 reset = 1'b1;
    repeat (6) @(posedge sys_clk);
    #1;
    chk("mid_p1",  int'(p1_attack_connected), 0);
    chk("mid_idle", int'(dut.state_q), int'(S_IDLE));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/combat_resolver.md
Name: combat_resolver

Overview:
- Sits directly downstream of the two per-player next-state calculators.
- Once per frame it waits until both players' state, sprite index and position for that frame are valid, then checks attack ranges and active frames.
- Drives each player's attack_connected / opponent_attack_connected inputs back to the calculators.
- Results are sticky: once a hit lands, the round is over until reset.

Parameters:
KICK_ACTIVE_START, 2, first sprite index (inclusive) on which a kick can hit
KICK_ACTIVE_END, 3, last sprite index (inclusive) on which a kick can hit
KICK_RANGE, 20, max gap in pixels between players for a kick to reach
GRAB_ACTIVE_FRAME, 1, only sprite index on which a grab can hit
GRAB_RANGE, 8, max gap in pixels between players for a grab to reach
TIMEOUT_CYCLES, 16, sys_clk cycles to wait for both done flags before forcing evaluation

Ports:
sys_clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
frame_clk  in  1  frame clock; treated as asynchronous, synchronised internally
p1_state  in  STATE_DEPTH  player 1 current state
p1_index  in  SPRITE_INDEX_DEPTH  player 1 sprite index / action timer
p1_position  in  POSITION_DEPTH  player 1 x position (left player)
p1_done  in  1  player 1 next-state generation complete
p2_state  in  STATE_DEPTH  player 2 current state
p2_index  in  SPRITE_INDEX_DEPTH  player 2 sprite index / action timer
p2_position  in  POSITION_DEPTH  player 2 x position (right player)
p2_done  in  1  player 2 next-state generation complete
p1_attack_connected  out  1  player 1 landed a hit (sticky)
p2_attack_connected  out  1  player 2 landed a hit (sticky)
round_over  out  1  high while either attack_connected output is high
resolve_valid  out  1  one-cycle pulse when a frame's evaluation completes
clash  out  1  one-cycle pulse, coincident with resolve_valid, when both attacks land
frame_overrun  out  1  sticky flag: a frame edge arrived before the previous evaluation finished

Behaviour:
- Reset (reset=0, async): every output 0, FSM in IDLE, timeout counter 0, sync flops 0.
- frame_clk: passes through a two-flop synchroniser, then a rising-edge detector, giving frame_edge (one sys_clk cycle wide).
- FSM states: IDLE, WAIT_DONE, COMPUTE, RESOLVE, LOCKED.
- IDLE: on frame_edge -> WAIT_DONE and clear the timeout counter.
- WAIT_DONE: counter increments every cycle.
  - -> COMPUTE when p1_done & p2_done, or when counter == TIMEOUT_CYCLES-1.
  - Timeout is not reported separately.
- COMPUTE: registers the following from the current inputs.
  - gap = p2_position - p1_position - PLAYER_WIDTH, saturating at 0 when p2_position < p1_position + PLAYER_WIDTH. Computed one bit wider than POSITION_DEPTH.
  - kick_active_pN = (state==KICK) & KICK_ACTIVE_START <= index <= KICK_ACTIVE_END & gap <= KICK_RANGE.
  - grab_active_pN = (state==GRAB) & index == GRAB_ACTIVE_FRAME & gap <= GRAB_RANGE.
- RESOLVE: uses only the values registered in COMPUTE.
  - lands_pN = (kick_active_pN & opponent state != BLOCK) | (grab_active_pN & opponent state != KICK).
  - Grab beats block; any-frame kick beats grab; block stops kick.
  - Both land: clash pulses, neither output set -> IDLE.
  - Exactly one lands: that player's attack_connected = 1 -> LOCKED.
  - Neither lands: -> IDLE.
  - resolve_valid pulses in RESOLVE in every case.
- Latency: first cycle after frame_edge where both done flags are high, plus 2 cycles, to resolve_valid.
- LOCKED: all frame edges ignored; outputs held until reset. frame_overrun is not set here.
- frame_edge while in WAIT_DONE, COMPUTE or RESOLVE:
  - frame_overrun set (sticky).
  - In RESOLVE, the current result is still committed.
  - FSM then goes to WAIT_DONE with the counter cleared, unless it enters LOCKED.
- Either player in WIN or LOSE state at COMPUTE: both lands forced to 0 (no re-trigger).
- p1_attack_connected and p2_attack_connected are never both 1.
- Reset mid-operation: immediate return to the reset values above.

Decomposition:
- Shared package (already holding STATE_DEPTH, SPRITE_INDEX_DEPTH, POSITION_DEPTH, PLAYER_WIDTH, state encodings NOTHING/WALK_*/BLOCK/KICK/GRAB/WIN/LOSE) gains:
  - KICK_ACTIVE_START/END, KICK_RANGE, GRAB_ACTIVE_FRAME, GRAB_RANGE defaults.
  - FSM state encoding.
- One sub-module: frame_edge_sync (two-flop synchroniser plus rising-edge detector), reusable by the calculators.

Test Plan:
- Kick in range: p1 KICK index 2; p1_position=100, p2_position=100+PLAYER_WIDTH+10; p2 NOTHING; both done -> resolve_valid 3 cycles later, p1_attack_connected=1, round_over=1; later frame edges ignored.
- Block stops kick: same setup with p2 BLOCK -> resolve_valid pulses, both outputs 0. Then p2 GRAB index 1 on the next frame at gap 5 -> p2_attack_connected=1.
- Clash and kick-beats-grab:
  - Both KICK index 3 at gap 15 -> clash=1, outputs 0.
  - p1 GRAB index 1 vs p2 KICK index 0 at gap 5 -> neither lands (p2 kick inactive, p1 grab blocked by KICK).
- Range boundaries:
  - Kick at gap 20 -> hit; gap 21 -> no hit.
  - Overlapping positions (p2_position = p1_position + 2) -> gap saturates to 0, kick hits.
- Timeout: p2_done held 0 -> evaluation still completes, resolve_valid at TIMEOUT_CYCLES+2 cycles after frame_edge.
- Overrun and reset: second frame_clk rise during WAIT_DONE -> frame_overrun=1, evaluation restarts. Assert reset mid-COMPUTE -> all outputs 0 immediately, FSM in IDLE.
